alu_writeback: RTL
==================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEPTH, default 2: result buffer entries, power of two, at least 2.
REQ-002 Parameter AW, default 3: register-file address width.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1: execute stage presents a completed ALU operation.
REQ-006 Port alu_ready, input, 1: ALU ready output; the operation is complete only when it is 1.
REQ-007 Port in_ready, output, 1: block can accept an operation.
REQ-008 Port res, input, 16: ALU result.
REQ-009 Port flag_next, input, 4: ALU flags; bit 3 Z, bit 2 N, bit 1 C, bit 0 O.
REQ-010 Port res_we, input, 1: operation writes a register (0 for compare-type ops).
REQ-011 Port flag_we, input, 1: operation updates flags.
REQ-012 Port dest, input, AW: destination register index.
REQ-013 Port flush, input, 1: synchronous discard of buffered results.
REQ-014 Port wb_valid, output, 1: register-file write pending at buffer head.
REQ-015 Port wb_ready, input, 1: register file accepts the write this cycle.
REQ-016 Port wb_data, output, 16: head entry data.
REQ-017 Port wb_addr, output, AW: head entry register index.
REQ-018 Ports Zflag, Nflag, Cflag, Oflag, output, 1 each: architectural flags; Cflag and Oflag feed the ALU's Cflag and Oflag inputs.
REQ-019 Port pending, output, log2(DEPTH)+1: buffered entry count.

Function
REQ-020 Accept = in_valid & alu_ready & in_ready; no state changes when accept is 0.
REQ-021 in_ready SHALL be 1 when pending < DEPTH and 0 when full; flags-only ops (res_we=0) are also blocked when full, preserving order.
REQ-022 On accept with flag_we=1, all four flags SHALL take flag_next on that edge (1-cycle latency); flag_we=0 leaves flags unchanged.
REQ-023 On accept with res_we=1, {dest,res} SHALL be pushed into the FIFO; res_we=0 pushes nothing.
REQ-024 Pop = wb_valid & wb_ready; the head advances on that edge.
REQ-025 wb_valid = (pending != 0); wb_data and wb_addr come straight from the head entry, with no combinational path from res or dest.
REQ-026 Simultaneous push and pop SHALL leave pending unchanged and keep FIFO order.
REQ-027 When full, a same-cycle pop does not re-open in_ready in that cycle; in_ready depends only on registered count.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 flush=1 SHALL set pending to 0 and both pointers to 0 on the next edge, overriding any same-cycle push or pop; flags are still updated by a same-cycle accept.
REQ-030 Behaviour is undefined when wb_ready=1 while wb_valid=0; pop is gated by wb_valid.

Reset
REQ-031 While rst=1: pending=0, pointers=0, wb_valid=0, in_ready=0, and all flags=0, applied asynchronously.
REQ-032 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-033 Reset asserted mid-transfer discards all buffered entries; no partial write is presented afterwards.
REQ-034 FIFO data storage needs no reset; only control state and flags are reset.

Structure
REQ-035 Flag bit indices Z=3, N=2, C=1, O=0 SHALL live in a shared flags include used by both this block and the ALU.
REQ-036 Storage SHALL be a sub-module wb_fifo (DEPTH x (AW+16), count, pointers, flush).
REQ-037 Flag register and accept logic SHALL live in alu_writeback itself.

Verification
REQ-038 Reset, then accept res=0x0005, dest=2, res_we=1, flag_we=1, flag_next=0000, with wb_ready=1 -> next cycle wb_valid=1, wb_addr=2, wb_data=0x0005, flags 0000; the cycle after, pending=0.
REQ-039 wb_ready=0, two accepts (0x1111 to r1, 0x2222 to r3) -> pending=2, in_ready=0; a third op is not accepted; wb_ready=1 drains r1 first, then r3.
REQ-040 Compare op with res_we=0, flag_we=1, flag_next=1000 -> Zflag=1, pending unchanged, wb_valid unchanged.
REQ-041 pending=1 with simultaneous push and pop for 10 cycles -> pending stays 1, data order preserved across pointer wrap.
REQ-042 pending=2, flush=1 together with accept flag_next=0010 -> pending=0, wb_valid=0, Cflag=1.
REQ-043 rst pulsed asynchronously mid-cycle with pending=2 -> outputs clear immediately, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared types and constants for the ALU writeback block.
// Holds the flag bit layout that the ALU and writeback agree on.
package alu_writeback_pkg;

    // Flag vector bit positions, shared with the ALU flag inputs.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;
    localparam int FLAG_W = 4;

    localparam int DATA_W = 16;

    // Packed so that bit 3 is Z and bit 0 is O, matching FLAG_*.
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic o;
    } flags_t;

    function automatic flags_t flags_from_vec(
        input logic [FLAG_W-1:0] v
    );
        flags_t f;
        f.z = v[FLAG_Z];
        f.n = v[FLAG_N];
        f.c = v[FLAG_C];
        f.o = v[FLAG_O];
        return f;
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Execute-to-writeback bundle: ALU op handshake, flush, register-file write
// port, architectural flags and buffer occupancy. master = execute side.
interface alu_writeback_if
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              alu_ready;
    logic              in_ready;
    logic [DATA_W-1:0] res;
    logic [FLAG_W-1:0] flag_next;
    logic              res_we;
    logic              flag_we;
    logic [AW-1:0]     dest;
    logic              flush;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [AW-1:0]     wb_addr;

    logic              Zflag;
    logic              Nflag;
    logic              Cflag;
    logic              Oflag;
    logic [CW-1:0]     pending;

    modport master (
        output in_valid, alu_ready, res, flag_next,
        output res_we, flag_we, dest, flush, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_addr,
        input  Zflag, Nflag, Cflag, Oflag, pending
    );

    modport slave (
        input  in_valid, alu_ready, res, flag_next,
        input  res_we, flag_we, dest, flush, wb_ready,
        output in_ready, wb_valid, wb_data, wb_addr,
        output Zflag, Nflag, Cflag, Oflag, pending
    );

endinterface

// File: rtl/alu_writeback_fifo.sv
// wb_fifo: DEPTH-entry result buffer with count, wrapping pointers, flush.
// Ports: clk, rst, push_i/push_data_i, pop_i, flush_i, head_o, count_o, full_o.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 19,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: accepts completed ALU ops, updates flags, buffers results.
// Ports: clk, rst, bus (alu_writeback_if.slave: op in, reg-file write out).
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 3
) (
    input  logic           clk,
    input  logic           rst,
    alu_writeback_if.slave bus
);

    localparam int W  = AW + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          live_q;
    flags_t        flags_q, flags_d;
    logic          in_ready;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          wb_valid;
    logic [W-1:0]  head;
    logic [CW-1:0] count;

    // live_q keeps in_ready low during reset and raises it one edge later.
    // in_ready depends on registered state only, so a pop never re-opens
    // a full buffer within the same cycle.
    assign in_ready = live_q & ~full;
    assign accept   = bus.in_valid & bus.alu_ready & in_ready;
    assign push     = accept & bus.res_we;
    assign wb_valid = (count != '0);
    assign pop      = wb_valid & bus.wb_ready;

    always_comb begin
        flags_d = flags_q;
        if (accept && bus.flag_we) begin
            flags_d = flags_from_vec(bus.flag_next);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            live_q  <= 1'b1;
            flags_q <= flags_d;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({bus.dest, bus.res}),
        .pop_i       (pop),
        .flush_i     (bus.flush),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full)
    );

    assign bus.in_ready = in_ready;
    assign bus.wb_valid = wb_valid;
    assign bus.wb_data  = head[DATA_W-1:0];
    assign bus.wb_addr  = head[W-1 -: AW];
    assign bus.pending  = count;
    assign bus.Zflag    = flags_q.z;
    assign bus.Nflag    = flags_q.n;
    assign bus.Cflag    = flags_q.c;
    assign bus.Oflag    = flags_q.o;

endmodule
